// File: rtl/dmem_arbiter_if.sv
// Signal bundle for dmem_arbiter: both requester ports plus the data-memory port.
// slave is the arbiter's view; master is the environment (requesters and memory).
interface dmem_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              m0_req_i;
  logic              m0_we_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [2:0]        m0_funct3_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic              m0_gnt_o;
  logic              m0_rvalid_o;
  logic [DATA_W-1:0] m0_rdata_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [2:0]        m1_funct3_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;
  logic [DATA_W-1:0] m1_rdata_o;

  logic              mem_st_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [2:0]        mem_funct3_o;
  logic [DATA_W-1:0] mem_st_data_o;
  logic [DATA_W-1:0] mem_ld_data_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_addr_i, m0_funct3_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_we_i, m1_addr_i, m1_funct3_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output mem_st_en_o, mem_addr_o, mem_funct3_o, mem_st_data_o,
    input  mem_ld_data_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_addr_i, m0_funct3_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_we_i, m1_addr_i, m1_funct3_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  mem_st_en_o, mem_addr_o, mem_funct3_o, mem_st_data_o,
    output mem_ld_data_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the byte-banked data memory, one access at a time.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; default build gives m0 fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [2:0] RD_LAT_CNT = 3'(RD_LAT);

  state_t            state;
  logic              owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] wdata_q;
  logic              st_en_q;
  logic [2:0]        wait_cnt;
  logic              m0_rvalid_q;
  logic              m1_rvalid_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;

  logic              gnt0;
  logic              gnt1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        sel_funct3;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  logic              last_winner;
`endif

  // Grants are combinational and only ever raised in IDLE; held low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_ni && state == IDLE) begin
      if (bus.m0_req_i && bus.m1_req_i) begin
`ifdef DMEM_ARB_RR_EN
        gnt0 = last_winner;
        gnt1 = !last_winner;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = bus.m0_req_i;
        gnt1 = bus.m1_req_i;
      end
    end
  end

  always_comb begin
    sel_we     = bus.m0_we_i;
    sel_addr   = bus.m0_addr_i;
    sel_funct3 = bus.m0_funct3_i;
    sel_wdata  = bus.m0_wdata_i;
    if (gnt1) begin
      sel_we     = bus.m1_we_i;
      sel_addr   = bus.m1_addr_i;
      sel_funct3 = bus.m1_funct3_i;
      sel_wdata  = bus.m1_wdata_i;
    end
  end

  // Address, funct3 and store data keep their last value between accesses; only st_en is pulsed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      owner       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      st_en_q     <= 1'b0;
      wait_cnt    <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
`ifdef DMEM_ARB_RR_EN
      last_winner <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            owner    <= gnt1;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            funct3_q <= sel_funct3;
            wdata_q  <= sel_wdata;
            st_en_q  <= sel_we;
            state    <= ACCESS;
`ifdef DMEM_ARB_RR_EN
            last_winner <= gnt1;
`endif
          end
        end

        ACCESS: begin
          st_en_q <= 1'b0;
          if (we_q) begin
            state <= RESP;
            if (owner) begin
              m1_rvalid_q <= 1'b1;
              m1_rdata_q  <= '0;
            end else begin
              m0_rvalid_q <= 1'b1;
              m0_rdata_q  <= '0;
            end
          end else begin
            state    <= WAIT;
            wait_cnt <= RD_LAT_CNT;
          end
        end

        // Load data is only trusted in the final wait cycle.
        WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
          if (wait_cnt == 3'd1) begin
            state <= RESP;
            if (owner) begin
              m1_rvalid_q <= 1'b1;
              m1_rdata_q  <= bus.mem_ld_data_i;
            end else begin
              m0_rvalid_q <= 1'b1;
              m0_rdata_q  <= bus.mem_ld_data_i;
            end
          end
        end

        RESP: begin
          m0_rvalid_q <= 1'b0;
          m1_rvalid_q <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.m0_gnt_o      = gnt0;
  assign bus.m1_gnt_o      = gnt1;
  assign bus.m0_rvalid_o   = m0_rvalid_q;
  assign bus.m1_rvalid_o   = m1_rvalid_q;
  assign bus.m0_rdata_o    = m0_rdata_q;
  assign bus.m1_rdata_o    = m1_rdata_q;
  assign bus.mem_st_en_o   = st_en_q;
  assign bus.mem_addr_o    = addr_q;
  assign bus.mem_funct3_o  = funct3_q;
  assign bus.mem_st_data_o = wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table-driven transactions with a response scoreboard,
// plus hand-written tie, mid-load reset, withdrawal and RD_LAT = 3 sequences.
module tb_dmem_arbiter;

  localparam int RD_LAT = 1;

  typedef struct {
    bit          port;
    bit          we;
    logic [12:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          port;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   gnt0_cnt = 0;
  int   gnt1_cnt = 0;
  int   st_cnt = 0;

  exp_t        sb[$];
  logic [31:0] held_rdata [0:1];
  logic [31:0] mem_words [0:2047];
  logic        mem_ready = 1'b0;
  logic [31:0] mem_w;
  logic [10:0] mem_idx;
  logic [31:0] ld3;

  dmem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus ();
  dmem_arbiter_if #(.ADDR_W(13), .DATA_W(32)) bus3 ();

  dmem_arbiter #(.ADDR_W(13), .DATA_W(32), .RD_LAT(RD_LAT)) u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  dmem_arbiter #(.ADDR_W(13), .DATA_W(32), .RD_LAT(3)) u_dut3 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  assign bus.mem_ld_data_i  = mem_words[bus.mem_addr_o[12:2]];
  assign bus3.mem_ld_data_i = ld3;

  // Byte-banked memory model: word i starts as 0x1000_0000 | i, except word 4 = 0xDEADBEEF.
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 2048; i++)
        mem_words[i] <= (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 | 32'(i));
      mem_ready <= 1'b1;
    end else if (bus.mem_st_en_o) begin
      mem_idx = bus.mem_addr_o[12:2];
      mem_w   = mem_words[mem_idx];
      case (bus.mem_funct3_o[1:0])
        2'b00:   mem_w[8*bus.mem_addr_o[1:0] +: 8] = bus.mem_st_data_o[7:0];
        2'b01:   mem_w[16*bus.mem_addr_o[1] +: 16] = bus.mem_st_data_o[15:0];
        default: mem_w = bus.mem_st_data_o;
      endcase
      mem_words[mem_idx] <= mem_w;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic report_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("[TB] FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // Scoreboard side: every response is checked against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.m0_gnt_o || bus.m1_gnt_o) begin
      checkOutput("gnt_onehot", 32'($countones({bus.m1_gnt_o, bus.m0_gnt_o})), 32'd1);
      if (bus.m0_gnt_o) gnt0_cnt++;
      if (bus.m1_gnt_o) gnt1_cnt++;
    end
    if (bus.mem_st_en_o) st_cnt++;
    if (bus.m0_rvalid_o || bus.m1_rvalid_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_rvalid: got m0=%b m1=%b, required no response", bus.m0_rvalid_o, bus.m1_rvalid_o);
      end else begin
        e = sb.pop_front();
        checkOutput("rvalid_port", 32'({bus.m1_rvalid_o, bus.m0_rvalid_o}), e.port ? 32'd2 : 32'd1);
        checkOutput("rvalid_cycle", 32'(cycle), 32'(e.cyc));
        checkOutput("rdata", e.port ? bus.m1_rdata_o : bus.m0_rdata_o, e.rdata);
        checkOutput("other_rdata_held", e.port ? bus.m0_rdata_o : bus.m1_rdata_o, held_rdata[!e.port]);
        held_rdata[e.port] = e.rdata;
      end
    end
  end

  task automatic drive_port(input bit port, input bit req, input bit we, input logic [12:0] addr,
                            input logic [2:0] f3, input logic [31:0] wdata);
    if (port) begin
      bus.m1_req_i = req; bus.m1_we_i = we; bus.m1_addr_i = addr;
      bus.m1_funct3_i = f3; bus.m1_wdata_i = wdata;
    end else begin
      bus.m0_req_i = req; bus.m0_we_i = we; bus.m0_addr_i = addr;
      bus.m0_funct3_i = f3; bus.m0_wdata_i = wdata;
    end
  endtask

  task automatic grant_wait(input bit port, output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if ((port ? bus.m1_gnt_o : bus.m0_gnt_o) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    if (!ok) report_timeout("gnt_timeout");
  endtask

  task automatic drain();
    for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
    if (sb.size() != 0) begin
      report_timeout("rvalid_timeout");
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; entered and left #1 after a rising edge.
  task automatic applyStimulus(input vec_t v, output int lat);
    bit   ok;
    exp_t e;
    drive_port(v.port, 1'b1, v.we, v.addr, v.funct3, v.wdata);
    grant_wait(v.port, ok, lat);
    if (!ok) begin
      drive_port(v.port, 1'b0, 1'b0, 13'h0, 3'h0, 32'h0);
      return;
    end
    e.port  = v.port;
    e.rdata = v.exp_rdata;
    e.cyc   = cycle + (v.we ? 2 : 2 + RD_LAT);
    sb.push_back(e);
    @(posedge clk);
    #1;
    drive_port(v.port, 1'b0, ~v.we, v.addr ^ 13'h1555, ~v.funct3, ~v.wdata);
    @(negedge clk);
    checkOutput("access_addr", 32'(bus.mem_addr_o), 32'(v.addr));
    checkOutput("access_funct3", 32'(bus.mem_funct3_o), 32'(v.funct3));
    checkOutput("access_st_en", 32'(bus.mem_st_en_o), 32'(v.we));
    if (v.we) checkOutput("access_st_data", bus.mem_st_data_o, v.wdata);
    @(posedge clk);
    @(negedge clk);
    checkOutput("after_access_st_en", 32'(bus.mem_st_en_o), 32'd0);
    checkOutput("after_access_addr", 32'(bus.mem_addr_o), 32'(v.addr));
    drain();
  endtask

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    vec_t vecs [8];
    vec_t v;
    int   lat;
    int   t3;
    int   st_before;
    int   g1_before;
    bit   ok;
    bit   won_m1;
    bit   exp_m1;
    exp_t e;

    vecs[0] = '{port:1'b0, we:1'b0, addr:13'h010,  funct3:3'd2, wdata:32'h0,        exp_rdata:32'hDEADBEEF};
    vecs[1] = '{port:1'b1, we:1'b1, addr:13'h023,  funct3:3'd0, wdata:32'h000000A5, exp_rdata:32'h0};
    vecs[2] = '{port:1'b0, we:1'b0, addr:13'h020,  funct3:3'd2, wdata:32'h0,        exp_rdata:32'hA5000008};
    vecs[3] = '{port:1'b0, we:1'b1, addr:13'h032,  funct3:3'd1, wdata:32'h0000BEEF, exp_rdata:32'h0};
    vecs[4] = '{port:1'b1, we:1'b0, addr:13'h030,  funct3:3'd2, wdata:32'h0,        exp_rdata:32'hBEEF000C};
    vecs[5] = '{port:1'b1, we:1'b1, addr:13'h040,  funct3:3'd2, wdata:32'hCAFEF00D, exp_rdata:32'h0};
    vecs[6] = '{port:1'b0, we:1'b0, addr:13'h041,  funct3:3'd4, wdata:32'h0,        exp_rdata:32'hCAFEF00D};
    vecs[7] = '{port:1'b1, we:1'b0, addr:13'h1FFC, funct3:3'd2, wdata:32'h0,        exp_rdata:32'h100007FF};

    rst_n = 1'b0;
    ld3   = 32'h0;
    held_rdata[0] = 32'h0;
    held_rdata[1] = 32'h0;
    drive_port(1'b0, 1'b0, 1'b0, 13'h0, 3'h0, 32'h0);
    drive_port(1'b1, 1'b0, 1'b0, 13'h0, 3'h0, 32'h0);
    bus3.m0_req_i = 1'b0; bus3.m0_we_i = 1'b0; bus3.m0_addr_i = 13'h0;
    bus3.m0_funct3_i = 3'h0; bus3.m0_wdata_i = 32'h0;
    bus3.m1_req_i = 1'b0; bus3.m1_we_i = 1'b0; bus3.m1_addr_i = 13'h0;
    bus3.m1_funct3_i = 3'h0; bus3.m1_wdata_i = 32'h0;

    #3;
    checkOutput("reset_m0_gnt", 32'(bus.m0_gnt_o), 32'd0);
    checkOutput("reset_m1_gnt", 32'(bus.m1_gnt_o), 32'd0);
    checkOutput("reset_m0_rvalid", 32'(bus.m0_rvalid_o), 32'd0);
    checkOutput("reset_m1_rvalid", 32'(bus.m1_rvalid_o), 32'd0);
    checkOutput("reset_m0_rdata", bus.m0_rdata_o, 32'd0);
    checkOutput("reset_m1_rdata", bus.m1_rdata_o, 32'd0);
    checkOutput("reset_mem_st_en", 32'(bus.mem_st_en_o), 32'd0);
    checkOutput("reset_mem_addr", 32'(bus.mem_addr_o), 32'd0);
    checkOutput("reset_mem_funct3", 32'(bus.mem_funct3_o), 32'd0);
    checkOutput("reset_mem_st_data", bus.mem_st_data_o, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] table-driven transactions");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput("single_req_gnt_latency", 32'(lat), 32'd0);
    end

    $display("[TB] reset during load wait");
    drive_port(1'b0, 1'b1, 1'b0, 13'h010, 3'd2, 32'h0);
    grant_wait(1'b0, ok, lat);
    @(posedge clk);
    #1;
    drive_port(1'b0, 1'b0, 1'b0, 13'h0, 3'h0, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_m0_rvalid", 32'(bus.m0_rvalid_o), 32'd0);
    checkOutput("midreset_m0_rdata", bus.m0_rdata_o, 32'd0);
    checkOutput("midreset_m1_rdata", bus.m1_rdata_o, 32'd0);
    checkOutput("midreset_mem_addr", 32'(bus.mem_addr_o), 32'd0);
    checkOutput("midreset_mem_funct3", 32'(bus.mem_funct3_o), 32'd0);
    held_rdata[0] = 32'h0;
    held_rdata[1] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = '{port:1'b1, we:1'b0, addr:13'h010, funct3:3'd2, wdata:32'h0, exp_rdata:32'hDEADBEEF};
    applyStimulus(v, lat);
    checkOutput("post_reset_first_idle_gnt", 32'(lat), 32'd0);

    $display("[TB] simultaneous requests");
    drive_port(1'b0, 1'b1, 1'b0, 13'h010, 3'd2, 32'h0);
    drive_port(1'b1, 1'b1, 1'b0, 13'h020, 3'd2, 32'h0);
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int c = 0; c < 12 && !ok; c++) begin
        @(negedge clk);
        if (bus.m0_gnt_o || bus.m1_gnt_o) ok = 1'b1;
        else begin
          @(posedge clk);
          #1;
        end
      end
      if (!ok) report_timeout("tie_gnt_timeout");
      else begin
        won_m1 = bus.m1_gnt_o;
`ifdef DMEM_ARB_RR_EN
        exp_m1 = (k % 2) == 1;
`else
        exp_m1 = 1'b0;
`endif
        checkOutput("tie_winner", 32'(won_m1), 32'(exp_m1));
        e.port  = won_m1;
        e.rdata = won_m1 ? 32'hA5000008 : 32'hDEADBEEF;
        e.cyc   = cycle + 2 + RD_LAT;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      if (k == 3) begin
        drive_port(1'b0, 1'b0, 1'b0, 13'h0, 3'h0, 32'h0);
        drive_port(1'b1, 1'b0, 1'b0, 13'h0, 3'h0, 32'h0);
      end
    end
    drain();

    $display("[TB] request withdrawn while another port owns the memory");
    st_before = st_cnt;
    g1_before = gnt1_cnt;
    drive_port(1'b0, 1'b1, 1'b1, 13'h060, 3'd2, 32'h5A5A1234);
    grant_wait(1'b0, ok, lat);
    if (ok) begin
      e.port  = 1'b0;
      e.rdata = 32'h0;
      e.cyc   = cycle + 2;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    drive_port(1'b0, 1'b0, 1'b0, 13'h0, 3'h0, 32'h0);
    drive_port(1'b1, 1'b1, 1'b1, 13'h064, 3'd2, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    drive_port(1'b1, 1'b0, 1'b0, 13'h0, 3'h0, 32'h0);
    drain();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("withdraw_m1_never_granted", 32'(gnt1_cnt - g1_before), 32'd0);
    checkOutput("withdraw_store_count", 32'(st_cnt - st_before), 32'd1);
    checkOutput("withdraw_m0_word", mem_words[24], 32'h5A5A1234);
    checkOutput("withdraw_m1_word_untouched", mem_words[25], 32'h10000019);

    $display("[TB] RD_LAT = 3 load");
    @(posedge clk);
    #1;
    bus3.m0_we_i = 1'b0; bus3.m0_addr_i = 13'h044; bus3.m0_funct3_i = 3'd2; bus3.m0_req_i = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 8 && !ok; c++) begin
      @(negedge clk);
      if (bus3.m0_gnt_o) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) report_timeout("lat3_gnt_timeout");
    t3 = cycle;
    @(posedge clk);
    #1;
    bus3.m0_req_i = 1'b0;
    ld3 = 32'h11111111;
    @(posedge clk);
    #1;
    ld3 = 32'h22222222;
    @(negedge clk);
    checkOutput("lat3_wait_addr", 32'(bus3.mem_addr_o), 32'h044);
    checkOutput("lat3_wait_st_en", 32'(bus3.mem_st_en_o), 32'd0);
    checkOutput("lat3_no_rvalid_t2", 32'(bus3.m0_rvalid_o), 32'd0);
    @(posedge clk);
    #1;
    ld3 = 32'h33333333;
    @(negedge clk);
    checkOutput("lat3_no_rvalid_t3", 32'(bus3.m0_rvalid_o), 32'd0);
    @(posedge clk);
    #1;
    ld3 = 32'h3C3CA5A5;
    @(negedge clk);
    checkOutput("lat3_no_rvalid_t4", 32'(bus3.m0_rvalid_o), 32'd0);
    checkOutput("lat3_last_wait_addr", 32'(bus3.mem_addr_o), 32'h044);
    @(posedge clk);
    #1;
    ld3 = 32'hFFFFFFFF;
    @(negedge clk);
    checkOutput("lat3_rvalid_t5", 32'(bus3.m0_rvalid_o), 32'd1);
    checkOutput("lat3_rvalid_cycle", 32'(cycle - t3), 32'd5);
    checkOutput("lat3_rdata", bus3.m0_rdata_o, 32'h3C3CA5A5);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat3_rvalid_one_cycle", 32'(bus3.m0_rvalid_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-banked data memory.
- Port m0 is the core load/store unit. Port m1 is a secondary master (program loader / debug).
- Grants one requester at a time and latches its command.
- Drives the memory port (st_en, addr, funct3, st_data) stable for the whole access, captures load data, and returns a one-cycle response to the owner.

Parameters:
- ADDR_W, 13, byte-address width; matches data memory addr width (8192 bytes).
- DATA_W, 32, data width.
- RD_LAT, 1, memory read latency in cycles from the access cycle to valid ld_data. Legal range 1..7.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- m0_req_i  in  1  m0 request; hold high with command fields stable until m0_gnt_o.
- m0_we_i  in  1  1 = store, 0 = load.
- m0_addr_i  in  ADDR_W  byte address.
- m0_funct3_i  in  3  RISC-V funct3 access size/sign (forwarded unchanged).
- m0_wdata_i  in  DATA_W  store data.
- m0_gnt_o  out  1  one-cycle pulse: command accepted.
- m0_rvalid_o  out  1  one-cycle pulse: transaction complete.
- m0_rdata_o  out  DATA_W  load data, valid with m0_rvalid_o.
- m1_req_i, m1_we_i, m1_addr_i, m1_funct3_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o  same as m0 for port 1.
- mem_st_en_o  out  1  memory store enable.
- mem_addr_o  out  ADDR_W  memory byte address.
- mem_funct3_o  out  3  memory funct3.
- mem_st_data_o  out  DATA_W  memory store data.
- mem_ld_data_i  in  DATA_W  memory load data.

Behaviour:
- Reset state:
  - State IDLE.
  - All outputs 0.
  - owner = 0; last-winner = 1, so m0 wins the first tie.
  - rdata registers = 0.
  - Reset mid-transaction drops the transaction: no rvalid is issued and any store not yet clocked is not performed.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - If any req is high, select a winner (see arbitration).
  - Assert the winner's gnt combinationally in this cycle (T).
  - Latch owner, we, addr, funct3, wdata at the clock edge; go to ACCESS.
  - The losing requester gets no gnt and must keep req high.
  - gnt is asserted only in IDLE.
- ACCESS (T+1):
  - mem_* driven from latched fields.
  - mem_st_en_o = latched we, for this cycle only.
  - Store: next state is RESP.
  - Load: next state is WAIT; load RD_LAT into the wait counter.
- WAIT:
  - mem_addr_o and mem_funct3_o held, mem_st_en_o = 0.
  - Counter decrements each cycle.
  - In the last WAIT cycle (counter = 1), capture mem_ld_data_i into the owner's rdata register, then go to RESP.
- RESP:
  - Owner's rvalid_o = 1 for exactly one cycle; rdata valid.
  - Stores return rdata = 0.
  - Then go to IDLE.
  - The non-owner's rvalid and rdata are not disturbed.
- Timing with gnt at cycle T:
  - Load: rvalid at T+2+RD_LAT (T+3 for RD_LAT = 1).
  - Store: rvalid at T+2; memory is written at the end of T+1.
- Memory outputs outside ACCESS/WAIT: mem_st_en_o = 0; addr, funct3, st_data hold their last values. Only st_en is qualified by state.
- Request withdrawn before gnt: legal, no side effects.
- Command fields are sampled only in the grant cycle. Changes after gnt are ignored.
- funct3 and address alignment are not checked; misaligned and unsupported codes pass through to memory.
- Outstanding transactions: at most one, no pipelining. Peak throughput is one load per RD_LAT+3 cycles or one store per 3 cycles.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration. On a tie, the port that is not last-winner wins; last-winner updates on every grant.
- Undefined: fixed priority, m0 always wins a tie; the last-winner register is not implemented.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset, then m0 load: m0 load addr 0x010 funct3 2 with memory word 0xDEADBEEF (RD_LAT = 1) -> gnt at T, mem_addr_o = 0x010 for T+1..T+2, m0_rvalid at T+3 with m0_rdata 0xDEADBEEF, m1 outputs stay 0.
- m1 store: m1 store addr 0x023 funct3 0 wdata 0x000000A5 -> mem_st_en_o high only at T+1 with mem_addr_o 0x023 and mem_funct3_o 0; m1_rvalid at T+2 with rdata 0.
- Tie with round robin: m0 and m1 both request loads continuously under DMEM_ARB_RR_EN -> grants alternate m0, m1, m0, m1. Without the macro, m0 is granted every time and m1 starves.
- Reset mid-load: assert rst_ni low during WAIT of an m0 load -> all outputs 0 at once, no m0_rvalid. After release, a fresh m1 request is granted in its first IDLE cycle.
- Withdrawal: m1_req pulses one cycle while m0 owns an access -> m1 is never granted and the memory sees only m0's transaction.
- RD_LAT = 3 build: load -> WAIT lasts 3 cycles, rvalid at T+5, and data is captured from mem_ld_data_i only in the last WAIT cycle (a changing value earlier is ignored).
